data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter WAIT_STATES, default 1: idle cycles between request capture and ack; legal range 0..15.
REQ-002 Parameter ADDR_W, default 8: address width; memory depth is 2**ADDR_W bytes.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 cen  input  1  clock enable; when low, every register holds its value.
REQ-006 data_cyc_i  input  1  bus cycle in progress.
REQ-007 data_stb_i  input  1  transfer strobe; a request is data_cyc_i & data_stb_i.
REQ-008 data_we_i  input  1  1 = write, 0 = read.
REQ-009 data_adr_i  input  ADDR_W  byte address.
REQ-010 data_dat_i  input  8  write data.
REQ-011 data_dat_o  output  8  read data; valid while data_ack_o is high.
REQ-012 data_ack_o  output  1  transfer-complete strobe, one cycle per transfer.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT, ACK, RECOVER; all transitions qualified by cen.
REQ-014 IDLE: on a request, the block SHALL capture adr, we, dat_i and go to WAIT (WAIT_STATES>0) or ACK (WAIT_STATES=0).
REQ-015 WAIT: a 4-bit counter SHALL load WAIT_STATES-1 on entry and decrement; at 0 the FSM SHALL go to ACK.
REQ-016 ACK: data_ack_o SHALL be 1 for exactly this one cycle; the FSM SHALL then go to RECOVER.
REQ-017 RECOVER: the block SHALL stay until data_stb_i is low, then go to IDLE, so a strobe held high after ack never yields a second ack.
REQ-018 Latency SHALL be request cycle to ack = WAIT_STATES+1 cycles.
REQ-019 A write SHALL commit the captured byte to the captured address on the cycle the FSM leaves ACK; it is not visible earlier.
REQ-020 A read SHALL register mem[captured adr] into data_dat_o on entry to ACK; data_dat_o SHALL hold until the next read completes.
REQ-021 Abort: if data_cyc_i drops in WAIT, the FSM SHALL return to IDLE with no ack and no write.
REQ-022 If data_cyc_i drops in the ACK cycle, the ack and write SHALL still complete.
REQ-023 Bus inputs SHALL be ignored outside IDLE; address changes mid-transfer have no effect.
REQ-024 Address SHALL wrap modulo 2**ADDR_W; no out-of-range error exists.
REQ-025 Read-after-write to the same address in back-to-back transfers SHALL return the new value.

Reset
REQ-026 With rst high at a rising clk edge (cen regardless), the FSM SHALL enter IDLE, counter clear, data_ack_o=0, data_dat_o=8'h00.
REQ-027 Reset SHALL NOT clear memory contents.
REQ-028 Reset mid-transfer SHALL abort it with no ack and no write.

Structure
REQ-029 State encoding and the WAIT_STATES maximum constant SHALL live in the shared Gumnut package alongside the control-unit state encodings.
REQ-030 Storage SHALL be one sub-module, data_mem_array (synchronous write, synchronous read, single port), instantiated once.
REQ-031 The FSM, counter and capture registers SHALL reside in data_mem_responder itself.

Verification
REQ-032 WAIT_STATES=1: write 8'hA5 to 8'h10, then read 8'h10 -> each ack 2 cycles after the request; read returns 8'hA5.
REQ-033 WAIT_STATES=0: strobe held high 5 cycles after one read -> exactly one ack pulse; RECOVER holds until stb falls.
REQ-034 WAIT_STATES=3: write 8'h3C to 8'h20, cyc dropped in the 2nd WAIT cycle -> no ack; a later read of 8'h20 returns the prior value.
REQ-035 ADDR_W=8: write 8'h77 to 8'hFF, then read 8'hFF -> 8'h77; write to 8'h00 leaves 8'hFF unchanged.
REQ-036 cen low for 4 cycles during WAIT -> ack delayed by exactly 4 cycles; read data unchanged.
REQ-037 rst pulsed during WAIT of a write -> data_ack_o=0, data_dat_o=8'h00, target byte unchanged, next transfer normal.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// +------------------------------------------------------------------+
// | data_mem_responder_pkg - shared Gumnut state encodings and limits |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

package data_mem_responder_pkg;

  localparam int WAIT_STATES_MAX = 15;
  localparam int WAIT_CNT_W      = 4;

  typedef enum logic [1:0] {
    DMR_IDLE    = 2'd0,
    DMR_WAIT    = 2'd1,
    DMR_ACK     = 2'd2,
    DMR_RECOVER = 2'd3
  } dmr_state_e;

  // Control-unit sequencing states of the Gumnut core.
  typedef enum logic [2:0] {
    CU_FETCH      = 3'd0,
    CU_DECODE     = 3'd1,
    CU_EXECUTE    = 3'd2,
    CU_MEM        = 3'd3,
    CU_WRITE_BACK = 3'd4,
    CU_INT        = 3'd5
  } cu_state_e;

  function automatic logic [WAIT_CNT_W-1:0] wait_load(input int ws);
    return (ws > 0) ? WAIT_CNT_W'(ws - 1) : '0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/data_mem_array.sv
// +------------------------------------------------------------------+
// | data_mem_array - single-port byte RAM, synchronous read and write |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module data_mem_array #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        wdat_i,
  output logic [7:0]        rdat_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdat_q;

  // Storage is never reset; only the read register is.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdat_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdat_q <= '0;
    end else if (re_i) begin
      rdat_q <= mem_q[addr_i];
    end
  end

  assign rdat_o = rdat_q;

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// +------------------------------------------------------------------+
// | data_mem_responder - wait-stated bus responder for the data RAM   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  input  logic              data_cyc_i,
  input  logic              data_stb_i,
  input  logic              data_we_i,
  input  logic [ADDR_W-1:0] data_adr_i,
  input  logic [7:0]        data_dat_i,
  output logic [7:0]        data_dat_o,
  output logic              data_ack_o
);

  localparam logic [WAIT_CNT_W-1:0] CNT_LOAD = wait_load(WAIT_STATES);

  dmr_state_e              state_q, state_d;
  logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]       adr_q, adr_d;
  logic                    we_q, we_d;
  logic [7:0]              wdat_q, wdat_d;
  logic                    req;
  logic                    mem_we;
  logic                    mem_re;

  assign req = data_cyc_i & data_stb_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DMR_IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      wdat_q  <= '0;
    end else if (cen) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      wdat_q  <= wdat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    we_d    = we_q;
    wdat_d  = wdat_q;
    case (state_q)
      DMR_IDLE: begin
        if (req) begin
          adr_d  = data_adr_i;
          we_d   = data_we_i;
          wdat_d = data_dat_i;
          if (WAIT_STATES == 0) begin
            state_d = DMR_ACK;
          end else begin
            state_d = DMR_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      DMR_WAIT: begin
        if (!data_cyc_i) begin
          state_d = DMR_IDLE;
        end else if (cnt_q == '0) begin
          state_d = DMR_ACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DMR_ACK: begin
        state_d = DMR_RECOVER;
      end
      DMR_RECOVER: begin
        // Hold here until the master releases the strobe so it cannot re-trigger.
        if (!data_stb_i) begin
          state_d = DMR_IDLE;
        end
      end
      default: begin
        state_d = DMR_IDLE;
      end
    endcase
  end

  // Read is sampled on entry to ACK, write commits on exit; they never share an edge.
  assign mem_re = cen & ~rst & (state_d == DMR_ACK) & ~we_d;
  assign mem_we = cen & ~rst & (state_q == DMR_ACK) & we_q;

  data_mem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk    (clk),
    .rst    (rst),
    .we_i   (mem_we),
    .re_i   (mem_re),
    .addr_i (adr_d),
    .wdat_i (wdat_q),
    .rdat_o (data_dat_o)
  );

  assign data_ack_o = (state_q == DMR_ACK);

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// +------------------------------------------------------------------+
// | tb_data_mem_responder - three responders (0/1/3 waits) vs model   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module tb_data_mem_responder;

  localparam int NDUT = 3;
  localparam int WS0  = 0;
  localparam int WS1  = 1;
  localparam int WS2  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst, cen, cyc, stb, we;
  logic [7:0]                adr, dat_in;
  logic [NDUT-1:0]           ack;
  logic [NDUT-1:0][7:0]      dout;

  data_mem_responder #(.WAIT_STATES(WS0), .ADDR_W(8)) u_dut0 (
    .clk(clk), .rst(rst), .cen(cen), .data_cyc_i(cyc), .data_stb_i(stb),
    .data_we_i(we), .data_adr_i(adr), .data_dat_i(dat_in),
    .data_dat_o(dout[0]), .data_ack_o(ack[0]));

  data_mem_responder #(.WAIT_STATES(WS1), .ADDR_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .cen(cen), .data_cyc_i(cyc), .data_stb_i(stb),
    .data_we_i(we), .data_adr_i(adr), .data_dat_i(dat_in),
    .data_dat_o(dout[1]), .data_ack_o(ack[1]));

  data_mem_responder #(.WAIT_STATES(WS2), .ADDR_W(8)) u_dut2 (
    .clk(clk), .rst(rst), .cen(cen), .data_cyc_i(cyc), .data_stb_i(stb),
    .data_we_i(we), .data_adr_i(adr), .data_dat_i(dat_in),
    .data_dat_o(dout[2]), .data_ack_o(ack[2]));

  function automatic int ws_of(input int k);
    case (k)
      0:       return WS0;
      1:       return WS1;
      default: return WS2;
    endcase
  endfunction

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc_n  = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Transaction-level reference: one pending transfer per responder.
  bit         m_busy [NDUT];
  int         m_left [NDUT];
  bit         m_ack  [NDUT];
  bit         m_rec  [NDUT];
  bit         m_we   [NDUT];
  logic [7:0] m_adr  [NDUT];
  logic [7:0] m_dat  [NDUT];
  logic [7:0] m_dout [NDUT];
  logic [7:0] m_mem  [NDUT][256];

  always @(posedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      if (rst) begin
        m_busy[k] = 1'b0; m_ack[k] = 1'b0; m_rec[k] = 1'b0; m_dout[k] = 8'h00;
      end else if (cen) begin
        if (m_ack[k]) begin
          if (m_we[k]) m_mem[k][m_adr[k]] = m_dat[k];
          m_ack[k] = 1'b0; m_rec[k] = 1'b1;
        end else if (m_rec[k]) begin
          if (!stb) m_rec[k] = 1'b0;
        end else if (m_busy[k]) begin
          if (!cyc) begin
            m_busy[k] = 1'b0;
          end else if (m_left[k] == 1) begin
            m_busy[k] = 1'b0; m_ack[k] = 1'b1;
            if (!m_we[k]) m_dout[k] = m_mem[k][m_adr[k]];
          end else begin
            m_left[k] = m_left[k] - 1;
          end
        end else if (cyc && stb) begin
          m_adr[k] = adr; m_we[k] = we; m_dat[k] = dat_in;
          if (ws_of(k) == 0) begin
            m_ack[k] = 1'b1;
            if (!m_we[k]) m_dout[k] = m_mem[k][m_adr[k]];
          end else begin
            m_busy[k] = 1'b1; m_left[k] = ws_of(k);
          end
        end
      end
    end
  end

  int         ack_cnt [NDUT];
  int         ack_cyc [NDUT];
  logic [7:0] ack_dat [NDUT];

  always @(negedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      if (ack[k] === 1'b1) begin
        ack_cnt[k] = ack_cnt[k] + 1;
        ack_cyc[k] = cyc_n;
        ack_dat[k] = dout[k];
      end
      if (chk_en) begin
        n_cmp = n_cmp + 1;
        if (ack[k] !== m_ack[k]) begin
          n_fail = n_fail + 1;
          $display("FAIL ack dut%0d cycle %0d: actual %b required %b", k, cyc_n, ack[k], m_ack[k]);
        end
        n_cmp = n_cmp + 1;
        if (dout[k] !== m_dout[k]) begin
          n_fail = n_fail + 1;
          $display("FAIL dat dut%0d cycle %0d: actual %h required %h", k, cyc_n, dout[k], m_dout[k]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  int base_cnt [NDUT];
  int req_c;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic xfer(input logic w, input logic [7:0] a, input logic [7:0] d,
                      input int hold, input int coff_at, input int coff_len);
    for (int k = 0; k < NDUT; k++) base_cnt[k] = ack_cnt[k];
    req_c = cyc_n;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_in = d;
    for (int i = 0; i < hold; i++) begin
      cen = !(i >= coff_at && i < coff_at + coff_len);
      tick();
    end
    cyc = 1'b0; stb = 1'b0; cen = 1'b1; we = 1'b0;
    adr = 8'($urandom); dat_in = 8'($urandom);
    tick(); tick();
  endtask

  task automatic lit_xfer(input string nm, input logic w, input logic [7:0] a,
                          input logic [7:0] d, input int hold,
                          input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
    logic [7:0] e;
    xfer(w, a, d, hold, 0, 0);
    for (int k = 0; k < NDUT; k++) begin
      e = (k == 0) ? e0 : (k == 1) ? e1 : e2;
      chk($sformatf("%s_dut%0d_nack", nm, k), ack_cnt[k] - base_cnt[k], 1);
      chk($sformatf("%s_dut%0d_lat", nm, k), ack_cyc[k] - req_c, ws_of(k) + 1);
      if (!w) chk($sformatf("%s_dut%0d_dat", nm, k), ack_dat[k], e);
    end
  endtask

  initial begin
    for (int k = 0; k < NDUT; k++) begin
      ack_cnt[k] = 0; ack_cyc[k] = 0; ack_dat[k] = 8'h00;
    end
    rst = 1'b1; cen = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    adr = 8'h00; dat_in = 8'h00;
    repeat (3) tick();
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("rst_ack_dut%0d", k), ack[k], 0);
      chk($sformatf("rst_dat_dut%0d", k), dout[k], 8'h00);
    end
    chk_en = 1'b1;
    rst = 1'b0; cen = 1'b1;
    tick();

    for (int a = 0; a < 256; a++) xfer(1'b1, 8'(a), 8'(a) ^ 8'h5A, 5, 0, 0);

    lit_xfer("wr10", 1'b1, 8'h10, 8'hA5, 5, 8'h00, 8'h00, 8'h00);
    lit_xfer("rd10", 1'b0, 8'h10, 8'h00, 5, 8'hA5, 8'hA5, 8'hA5);
    lit_xfer("rdhold", 1'b0, 8'h10, 8'h00, 9, 8'hA5, 8'hA5, 8'hA5);

    lit_xfer("wr20", 1'b1, 8'h20, 8'h11, 5, 8'h00, 8'h00, 8'h00);
    xfer(1'b1, 8'h20, 8'h3C, 2, 0, 0);
    chk("abort_dut2_nack", ack_cnt[2] - base_cnt[2], 0);
    chk("abort_dut1_nack", ack_cnt[1] - base_cnt[1], 1);
    lit_xfer("rd20", 1'b0, 8'h20, 8'h00, 5, 8'h3C, 8'h3C, 8'h11);

    lit_xfer("wrFF", 1'b1, 8'hFF, 8'h77, 5, 8'h00, 8'h00, 8'h00);
    lit_xfer("wr00", 1'b1, 8'h00, 8'h12, 5, 8'h00, 8'h00, 8'h00);
    lit_xfer("rdFF", 1'b0, 8'hFF, 8'h00, 5, 8'h77, 8'h77, 8'h77);
    lit_xfer("rd00", 1'b0, 8'h00, 8'h00, 5, 8'h12, 8'h12, 8'h12);

    lit_xfer("wr33", 1'b1, 8'h33, 8'hC3, 5, 8'h00, 8'h00, 8'h00);
    lit_xfer("rd33", 1'b0, 8'h33, 8'h00, 5, 8'hC3, 8'hC3, 8'hC3);

    xfer(1'b0, 8'h10, 8'h00, 9, 1, 4);
    chk("cen_dut2_lat", ack_cyc[2] - req_c, 8);
    chk("cen_dut1_lat", ack_cyc[1] - req_c, 6);
    chk("cen_dut2_nack", ack_cnt[2] - base_cnt[2], 1);
    chk("cen_dut2_dat", ack_dat[2], 8'hA5);

    lit_xfer("wr40", 1'b1, 8'h40, 8'h5A, 5, 8'h00, 8'h00, 8'h00);
    for (int k = 0; k < NDUT; k++) base_cnt[k] = ack_cnt[k];
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 8'h40; dat_in = 8'hEE;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("midrst_ack_dut%0d", k), ack[k], 0);
      chk($sformatf("midrst_dat_dut%0d", k), dout[k], 8'h00);
    end
    chk("midrst_dut2_nack", ack_cnt[2] - base_cnt[2], 0);
    tick(); tick();
    lit_xfer("rd40", 1'b0, 8'h40, 8'h00, 5, 8'hEE, 8'h5A, 8'h5A);

    for (int i = 0; i < 2500; i++) begin
      cyc    = ($urandom % 4) != 0;
      stb    = cyc ? (($urandom % 3) != 0) : (($urandom % 4) == 0);
      we     = $urandom % 2;
      adr    = ($urandom % 2) ? 8'($urandom % 8) : 8'($urandom);
      dat_in = 8'($urandom);
      cen    = ($urandom % 8) != 0;
      rst    = ($urandom % 200) == 0;
      tick();
    end
    rst = 1'b0; cen = 1'b1; cyc = 1'b0; stb = 1'b0;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
